// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB-first, one bit per clock.
// A three-state FSM (IDLE -> SHIFT x WIDTH -> DONE) sequences the operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             bor;
  logic [CW-1:0]    cnt;

  logic             a0, b0, d, bor_nx, last;
  logic [WIDTH-1:0] res_nx;

  // Full-subtractor cell applied to the current LSB pair.
  always_comb begin
    a0     = a_sr[0];
    b0     = b_sr[0];
    d      = a0 ^ b0 ^ bor;
    bor_nx = (~a0 & b0) | (~a0 & bor) | (b0 & bor);
    res_nx = {d, res_sr[WIDTH-1:1]};
    last   = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Unused encoding falls to the default arm and returns to IDLE with busy/done low.
  always_comb begin
    state_nx = IDLE;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  state_nx = start ? SHIFT : IDLE;
      SHIFT: begin
        busy     = 1'b1;
        state_nx = last ? DONE : SHIFT;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bor        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b;
          res_sr <= '0;
          bor    <= 1'b0;
          cnt    <= '0;
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nx;
          bor    <= bor_nx;
          cnt    <= cnt + 1'b1;
          // Publish only on the final bit so diff holds the previous result meanwhile.
          if (last) begin
            diff       <= res_nx;
            borrow_out <= bor_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random checks of serial_subtractor (WIDTH=8) with immediate assertions.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [7:0] diff;
  logic       borrow_out, busy, done;

  int vecs = 0;
  int miscmp = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one op from IDLE and checks timing and result; returns one cycle after done.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] ref9;
    logic [7:0] pd;
    int cyc, nb;
    logic held;
    ref9  = {1'b0, av} - {1'b0, bv};
    pd    = diff;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; nb = 0; held = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (diff !== pd) held = 1'b0;
      tick();
      cyc++;
    end
    chk("done_seen",    {31'b0, done}, 32'd1);
    chk("busy_cycles",  nb, 32'd8);
    chk("diff_held",    {31'b0, held}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("diff",         {24'b0, diff}, {24'b0, ref9[7:0]});
    chk("borrow",       {31'b0, borrow_out}, {31'b0, ref9[8]});
    tick();
    chk("done_1cyc",    {31'b0, done}, 32'd0);
  endtask

  initial begin
    int nd, cyc;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_diff",   {24'b0, diff}, 32'd0);
    chk("rst_borrow", {31'b0, borrow_out}, 32'd0);
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Basic vectors
    do_op(8'h5A, 8'h3C);
    do_op(8'h00, 8'h01);
    do_op(8'hA5, 8'hA5);

    // start held 12 cycles, operands change after the first
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();                                   // after E0
    a = 8'hFF; b = 8'h00;
    nd = 0;
    for (int k = 1; k <= 11; k++) begin
      if (done) begin
        nd++;
        chk("hold_first_diff",   {24'b0, diff}, 32'hF0);
        chk("hold_first_borrow", {31'b0, borrow_out}, 32'd1);
      end
      tick();
    end
    start = 1'b0;                             // after E11
    chk("hold_one_done", nd, 32'd1);
    chk("hold_restart_busy", {31'b0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin tick(); cyc++; end
    chk("hold_second_lat",    cyc, 32'd7);
    chk("hold_second_diff",   {24'b0, diff}, 32'hFF);
    chk("hold_second_borrow", {31'b0, borrow_out}, 32'd0);
    tick();

    // Abort mid-operation with an async reset pulse
    a = 8'h80; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();                   // three SHIFT edges done
    #2 rst = 1'b1;
    #1;
    chk("abort_diff", {24'b0, diff}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    #1 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || diff !== 8'h00) nd++;
    end
    chk("abort_quiet", nd, 32'd0);
    do_op(8'h80, 8'h01);

    // Random back-to-back operations
    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    do_op(8'hFF, 8'hFF);
    do_op(8'h00, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
